// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game-state controller: accepts moves, alternates players,
// rejects illegal moves, detects win/draw and drives the renderer's occupancy vectors.
module ttt_game_ctrl #(
  parameter logic FIRST_PLAYER = 1'b0,
  parameter logic ALT_START    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic [8:0] purp,
  output logic [8:0] gold,
  output logic       turn,
  output logic       illegal,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [7:0] win_lines,
  output logic [3:0] move_cnt
);

  typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

  state_t      state_q;
  logic [8:0]  purp_q, gold_q;
  logic        turn_q, starter_q, illegal_q;
  logic [1:0]  winner_q;
  logic [7:0]  win_lines_q;
  logic [3:0]  cnt_q;

  logic [15:0] occ_d;
  logic        legal_d;
  logic [8:0]  place_d;
  logic [8:0]  mover_d;
  logic [7:0]  lines_d;

  always_comb begin
    occ_d   = {7'd0, purp_q | gold_q};
    legal_d = (move_pos <= 4'd8) && !occ_d[move_pos];
    place_d = 9'd1 << move_pos;
    mover_d = turn_q ? gold_q : purp_q;
    lines_d = {&{mover_d[2], mover_d[4], mover_d[6]},
               &{mover_d[0], mover_d[4], mover_d[8]},
               &{mover_d[2], mover_d[5], mover_d[8]},
               &{mover_d[1], mover_d[4], mover_d[7]},
               &{mover_d[0], mover_d[3], mover_d[6]},
               &mover_d[8:6], &mover_d[5:3], &mover_d[2:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= PLAY;
      purp_q      <= '0;
      gold_q      <= '0;
      turn_q      <= FIRST_PLAYER;
      starter_q   <= FIRST_PLAYER;
      illegal_q   <= 1'b0;
      winner_q    <= '0;
      win_lines_q <= '0;
      cnt_q       <= '0;
    end else if (new_game) begin
      state_q     <= PLAY;
      purp_q      <= '0;
      gold_q      <= '0;
      illegal_q   <= 1'b0;
      winner_q    <= '0;
      win_lines_q <= '0;
      cnt_q       <= '0;
      // starter_q remembers who opened the last game so ALT_START can alternate it
      if (ALT_START) begin
        turn_q    <= ~starter_q;
        starter_q <= ~starter_q;
      end else begin
        turn_q    <= FIRST_PLAYER;
      end
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        PLAY: begin
          if (move_valid) begin
            if (legal_d) begin
              if (turn_q) gold_q <= gold_q | place_d;
              else        purp_q <= purp_q | place_d;
              cnt_q   <= cnt_q + 4'd1;
              state_q <= CHECK;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        CHECK: begin
          illegal_q   <= move_valid;
          win_lines_q <= lines_d;
          if (|lines_d) begin
            winner_q <= turn_q ? 2'b10 : 2'b01;
            state_q  <= OVER;
          end else if (cnt_q == 4'd9) begin
            winner_q <= 2'b11;
            state_q  <= OVER;
          end else begin
            turn_q   <= ~turn_q;
            state_q  <= PLAY;
          end
        end
        OVER:    illegal_q <= move_valid;
        default: state_q   <= PLAY;
      endcase
    end
  end

  assign move_ready = (state_q == PLAY);
  assign game_over  = (state_q == OVER);
  assign purp       = purp_q;
  assign gold       = gold_q;
  assign turn       = turn_q;
  assign illegal    = illegal_q;
  assign winner     = winner_q;
  assign win_lines  = win_lines_q;
  assign move_cnt   = cnt_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Bench for ttt_game_ctrl: two instances (fixed and alternating starter) driven by
// directed games then random stimulus, each compared against a board-level game model.
module tb_ttt_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, new_game, move_valid;
  logic [3:0] move_pos;

  logic       move_ready [2];
  logic [8:0] purp       [2];
  logic [8:0] gold       [2];
  logic       turn       [2];
  logic       illegal    [2];
  logic       game_over  [2];
  logic [1:0] winner     [2];
  logic [7:0] win_lines  [2];
  logic [3:0] move_cnt   [2];

  ttt_game_ctrl #(.FIRST_PLAYER(1'b0), .ALT_START(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid),
    .move_pos(move_pos), .move_ready(move_ready[0]), .purp(purp[0]), .gold(gold[0]),
    .turn(turn[0]), .illegal(illegal[0]), .game_over(game_over[0]), .winner(winner[0]),
    .win_lines(win_lines[0]), .move_cnt(move_cnt[0]));

  ttt_game_ctrl #(.FIRST_PLAYER(1'b1), .ALT_START(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid),
    .move_pos(move_pos), .move_ready(move_ready[1]), .purp(purp[1]), .gold(gold[1]),
    .turn(turn[1]), .illegal(illegal[1]), .game_over(game_over[1]), .winner(winner[1]),
    .win_lines(win_lines[1]), .move_cnt(move_cnt[1]));

  localparam bit MFP [2] = '{1'b0, 1'b1};
  localparam bit MALT[2] = '{1'b0, 1'b1};
  localparam int LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                               '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  // cells: 0 empty, 1 purple, 2 gold; phase: 0 awaiting move, 1 judging, 2 finished
  int         cells   [2][9];
  int         phase   [2];
  int         m_cnt   [2];
  int         m_win   [2];
  bit         m_turn  [2];
  bit         m_start [2];
  bit         m_ill   [2];
  logic [7:0] m_lines [2];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] board_of(int k, int who);
    logic [8:0] b = '0;
    for (int i = 0; i < 9; i++) if (cells[k][i] == who) b[i] = 1'b1;
    return b;
  endfunction

  task automatic clear_game(int k);
    for (int i = 0; i < 9; i++) cells[k][i] = 0;
    phase[k] = 0; m_cnt[k] = 0; m_win[k] = 0; m_ill[k] = 1'b0; m_lines[k] = '0;
  endtask

  task automatic model_step(int k, bit r, bit ng, bit mv, int pos);
    if (!r) begin
      clear_game(k);
      m_turn[k] = MFP[k]; m_start[k] = MFP[k];
    end else if (ng) begin
      clear_game(k);
      if (MALT[k]) begin m_start[k] = !m_start[k]; m_turn[k] = m_start[k]; end
      else m_turn[k] = MFP[k];
    end else if (phase[k] == 0) begin
      m_ill[k] = 1'b0;
      if (mv) begin
        if (pos <= 8 && cells[k][pos] == 0) begin
          cells[k][pos] = m_turn[k] ? 2 : 1;
          m_cnt[k]++;
          phase[k] = 1;
        end else m_ill[k] = 1'b1;
      end
    end else if (phase[k] == 1) begin
      int who = m_turn[k] ? 2 : 1;
      m_ill[k] = mv;
      for (int l = 0; l < 8; l++)
        m_lines[k][l] = (cells[k][LN[l][0]] == who) && (cells[k][LN[l][1]] == who) &&
                        (cells[k][LN[l][2]] == who);
      if (m_lines[k] != 0) begin m_win[k] = who; phase[k] = 2; end
      else if (m_cnt[k] == 9) begin m_win[k] = 3; phase[k] = 2; end
      else begin m_turn[k] = !m_turn[k]; phase[k] = 0; end
    end else begin
      m_ill[k] = mv;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("purp%0d", k),      purp[k],       board_of(k, 1));
      check($sformatf("gold%0d", k),      gold[k],       board_of(k, 2));
      check($sformatf("turn%0d", k),      turn[k],       m_turn[k]);
      check($sformatf("illegal%0d", k),   illegal[k],    m_ill[k]);
      check($sformatf("ready%0d", k),     move_ready[k], phase[k] == 0);
      check($sformatf("over%0d", k),      game_over[k],  phase[k] == 2);
      check($sformatf("winner%0d", k),    winner[k],     m_win[k]);
      check($sformatf("win_lines%0d", k), win_lines[k],  m_lines[k]);
      check($sformatf("move_cnt%0d", k),  move_cnt[k],   m_cnt[k]);
      check($sformatf("disjoint%0d", k),  purp[k] & gold[k], 0);
    end
  endtask

  // Compare the state left by the previous edge, then apply this cycle's inputs.
  task automatic cycle(bit r, bit ng, bit mv, int pos);
    @(negedge clk);
    compare_all();
    rst_n = r; new_game = ng; move_valid = mv; move_pos = 4'(pos);
    for (int k = 0; k < 2; k++) model_step(k, r, ng, mv, pos);
  endtask

  int row_seq  [5] = '{0, 3, 1, 4, 2};
  int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    rst_n = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_pos = '0;
    for (int k = 0; k < 2; k++) model_step(k, 1'b0, 1'b0, 1'b0, 0);
    cycle(1, 0, 0, 0);
    check("rst_ready", move_ready[0], 1);
    check("rst_turn1", turn[1], 1);

    foreach (row_seq[i]) begin cycle(1, 0, 1, row_seq[i]); cycle(1, 0, 0, 0); end
    cycle(1, 0, 0, 0);
    check("row_purp", purp[0], 9'h007);
    check("row_gold", gold[0], 9'h018);
    check("row_winner", winner[0], 2'b01);
    check("row_lines", win_lines[0], 8'h01);
    check("row_over", game_over[0], 1);

    cycle(1, 1, 1, 4);
    cycle(1, 0, 1, 4); cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 4); cycle(1, 0, 0, 0);
    check("dup_illegal", illegal[0], 1);
    cycle(1, 0, 1, 12); cycle(1, 0, 0, 0);

    cycle(1, 1, 0, 0);
    foreach (draw_seq[i]) begin cycle(1, 0, 1, draw_seq[i]); cycle(1, 0, 0, 0); end
    cycle(1, 0, 1, 4);
    check("draw_cnt", move_cnt[0], 9);
    check("draw_winner", winner[0], 2'b11);
    check("draw_lines", win_lines[0], 8'h00);
    cycle(1, 0, 0, 0);
    check("tenth_illegal", illegal[0], 1);

    cycle(1, 1, 0, 0);
    cycle(1, 0, 1, 0); cycle(1, 0, 1, 1); cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 5); cycle(0, 0, 0, 0); cycle(1, 0, 0, 0);

    for (int n = 0; n < 4000; n++) begin
      bit r  = ($urandom_range(0, 199) != 0);
      bit ng = ($urandom_range(0, 39) == 0);
      bit mv = $urandom_range(0, 1) == 1;
      int p  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15))
                                           : int'($urandom_range(0, 8));
      cycle(r, ng, mv, p);
    end
    cycle(1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
